// File: rtl/video_frame_sequencer.sv
// Pixel cadence, raster position and per-frame game-update scheduling for the HDMI pong design.
// All logic runs in the 5x pixel clock domain; decodes are combinational from the registered counters.
module video_frame_sequencer #(
  parameter int unsigned DIV     = 5,
  parameter int unsigned HPIXELS = 800,
  parameter int unsigned VLINES  = 525,
  parameter int unsigned HPULSE  = 96,
  parameter int unsigned VPULSE  = 2,
  parameter int unsigned HBP     = 144,
  parameter int unsigned HFP     = 784,
  parameter int unsigned VBP     = 35,
  parameter int unsigned VFP     = 515
) (
  input  logic       clk_x5,
  input  logic       resetn,
  output logic       pix_stb,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic [9:0] hac,
  output logic [9:0] vac,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       upd_req,
  input  logic       upd_ack,
  output logic       upd_busy,
  output logic [7:0] overrun_cnt
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST  = 10'(VLINES - 1);
  localparam logic [9:0] H_PULSE = 10'(HPULSE);
  localparam logic [9:0] V_PULSE = 10'(VPULSE);
  localparam logic [9:0] H_BP    = 10'(HBP);
  localparam logic [9:0] H_FP    = 10'(HFP);
  localparam logic [9:0] V_BP    = 10'(VBP);
  localparam logic [9:0] V_FP    = 10'(VFP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic [DW-1:0] div_q, div_d;
  logic          pix_stb_q, pix_stb_d;
  logic [9:0]    hc_q, hc_d, vc_q, vc_d;
  state_e        state_q, state_d;
  logic          upd_req_q, upd_req_d;
  logic          upd_busy_q, upd_busy_d;
  logic [7:0]    overrun_q, overrun_d;
  logic          adv_s, vfp_hit_s, timeout_hit_s;

  // Divider and raster counters; counters step on the edge that raises pix_stb.
  always_comb begin
    div_d = div_q;
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (div_q >= DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
    adv_s     = (div_d == DIV_LAST);
    pix_stb_d = adv_s;
    if (adv_s) begin
      if (hc_q >= H_LAST) begin
        hc_d = 10'd0;
        if (vc_q >= V_LAST) begin
          vc_d = 10'd0;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
      end
    end else begin
      hc_d = hc_q;
      vc_d = vc_q;
    end
    vfp_hit_s     = adv_s && (hc_d == 10'd0) && (vc_d == V_FP);
    timeout_hit_s = adv_s && (hc_d == 10'd0) && (vc_d == V_BP);
  end

  // Raster state registers.
  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) begin
      div_q     <= '0;
      pix_stb_q <= 1'b0;
      hc_q      <= 10'd0;
      vc_q      <= 10'd0;
    end else begin
      div_q     <= div_d;
      pix_stb_q <= pix_stb_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
    end
  end

  // Update FSM state register.
  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Update FSM next state; an ack in the timeout cycle takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (vfp_hit_s) state_d = ST_REQ;
        else           state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (upd_ack)            state_d = ST_DONE;
        else if (timeout_hit_s) state_d = ST_IDLE;
        else                    state_d = ST_REQ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Update FSM outputs, computed from the next state so they register alongside it.
  always_comb begin
    upd_req_d  = (state_d == ST_REQ);
    upd_busy_d = (state_d != ST_IDLE);
    overrun_d  = overrun_q;
    if ((state_q == ST_REQ) && !upd_ack && timeout_hit_s && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Update FSM output registers.
  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) begin
      upd_req_q  <= 1'b0;
      upd_busy_q <= 1'b0;
      overrun_q  <= 8'd0;
    end else begin
      upd_req_q  <= upd_req_d;
      upd_busy_q <= upd_busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign pix_stb     = pix_stb_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign hac         = hc_q - H_BP;
  assign vac         = vc_q - V_BP;
  assign active      = (hc_q >= H_BP) && (hc_q < H_FP) && (vc_q >= V_BP) && (vc_q < V_FP);
  assign hsync       = (hc_q < H_PULSE);
  assign vsync       = (vc_q < V_PULSE);
  assign upd_req     = upd_req_q;
  assign upd_busy    = upd_busy_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_video_frame_sequencer.sv
// Directed bench for video_frame_sequencer using a shrunken raster (8x6 pixels, DIV 5)
// so that hundreds of frames fit in a short run.
module tb_video_frame_sequencer;

  logic       clk_x5 = 1'b0;
  logic       resetn = 1'b0;
  logic       upd_ack = 1'b0;
  logic       pix_stb, active, hsync, vsync, upd_req, upd_busy;
  logic [9:0] hc, vc, hac, vac;
  logic [7:0] overrun_cnt;

  int checks = 0;
  int errors = 0;

  // Raster: DIV=5, 8 pixels x 6 lines, hsync hc<2, vsync vc<1, active hc 2..6, vc 1..4.
  video_frame_sequencer #(
    .DIV(5), .HPIXELS(8), .VLINES(6), .HPULSE(2), .VPULSE(1),
    .HBP(2), .HFP(7), .VBP(1), .VFP(5)
  ) dut (
    .clk_x5(clk_x5), .resetn(resetn), .pix_stb(pix_stb),
    .hc(hc), .vc(vc), .hac(hac), .vac(vac),
    .active(active), .hsync(hsync), .vsync(vsync),
    .upd_req(upd_req), .upd_ack(upd_ack), .upd_busy(upd_busy),
    .overrun_cnt(overrun_cnt)
  );

  always #4 clk_x5 = ~clk_x5;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the strobe sample that carries the given position.
  task automatic wait_strobe(input int h, input int v, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk_x5);
      if (pix_stb && hc == 10'(h) && vc == 10'(v)) found = 1'b1;
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  initial begin
    logic [9:0] exp_hac;
    int         req_highs;
    bit         found;

    repeat (3) @(negedge clk_x5);
    check_eq("rst_pix_stb", 32'(pix_stb), 32'd0);
    check_eq("rst_hc", 32'(hc), 32'd0);
    check_eq("rst_vc", 32'(vc), 32'd0);
    check_eq("rst_hac", 32'(hac), 32'd1022);
    check_eq("rst_vac", 32'(vac), 32'd1023);
    check_eq("rst_active", 32'(active), 32'd0);
    check_eq("rst_hsync", 32'(hsync), 32'd1);
    check_eq("rst_vsync", 32'(vsync), 32'd1);
    check_eq("rst_upd_req", 32'(upd_req), 32'd0);
    check_eq("rst_upd_busy", 32'(upd_busy), 32'd0);
    check_eq("rst_overrun", 32'(overrun_cnt), 32'd0);

    resetn = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk_x5);
      check_eq("stb_cadence", 32'(pix_stb), ((n % 5) == 4) ? 32'd1 : 32'd0);
      if (n == 4) check_eq("first_stb_hc", 32'(hc), 32'd1);
      if (n == 9) check_eq("second_stb_hc", 32'(hc), 32'd2);
    end

    // Line wrap and per-pixel decodes over the first active line.
    wait_strobe(7, 0, "reach_h7_v0");
    check_eq("v0_active", 32'(active), 32'd0);
    check_eq("h7_hsync", 32'(hsync), 32'd0);
    check_eq("v0_vsync", 32'(vsync), 32'd1);
    check_eq("v0_vac", 32'(vac), 32'd1023);
    for (int k = 0; k < 8; k++) begin
      repeat (5) @(negedge clk_x5);
      exp_hac = 10'(k) - 10'd2;
      check_eq("line_stb", 32'(pix_stb), 32'd1);
      check_eq("line_hc", 32'(hc), 32'(k));
      check_eq("line_vc", 32'(vc), 32'd1);
      check_eq("line_hsync", 32'(hsync), (k < 2) ? 32'd1 : 32'd0);
      check_eq("line_active", 32'(active), (k >= 2 && k < 7) ? 32'd1 : 32'd0);
      check_eq("line_hac", 32'(hac), 32'(exp_hac));
      check_eq("line_vac", 32'(vac), 32'd0);
      check_eq("line_vsync", 32'(vsync), 32'd0);
    end

    // Handshake with ack three cycles after the request.
    wait_strobe(7, 4, "reach_h7_v4");
    check_eq("pre_req_low", 32'(upd_req), 32'd0);
    repeat (5) @(negedge clk_x5);
    check_eq("req_pos_hc", 32'(hc), 32'd0);
    check_eq("req_pos_vc", 32'(vc), 32'd5);
    check_eq("req_rise", 32'(upd_req), 32'd1);
    check_eq("req_busy", 32'(upd_busy), 32'd1);
    check_eq("vfp_active", 32'(active), 32'd0);
    repeat (3) @(negedge clk_x5);
    check_eq("req_held", 32'(upd_req), 32'd1);
    upd_ack = 1'b1;
    @(negedge clk_x5);
    upd_ack = 1'b0;
    check_eq("ack_req_low", 32'(upd_req), 32'd0);
    check_eq("done_busy", 32'(upd_busy), 32'd1);
    @(negedge clk_x5);
    check_eq("idle_busy", 32'(upd_busy), 32'd0);
    check_eq("idle_req", 32'(upd_req), 32'd0);
    check_eq("ack_no_overrun", 32'(overrun_cnt), 32'd0);

    // Frame wrap and first active pixel.
    wait_strobe(7, 5, "reach_h7_v5");
    repeat (5) @(negedge clk_x5);
    check_eq("fwrap_hc", 32'(hc), 32'd0);
    check_eq("fwrap_vc", 32'(vc), 32'd0);
    check_eq("fwrap_vsync", 32'(vsync), 32'd1);
    wait_strobe(2, 1, "reach_h2_v1");
    check_eq("first_act", 32'(active), 32'd1);
    check_eq("first_hac", 32'(hac), 32'd0);
    check_eq("first_vac", 32'(vac), 32'd0);

    // Missed update: request dropped at the next frame's first active line.
    wait_strobe(0, 5, "ovr_req_pos");
    check_eq("ovr_req_up", 32'(upd_req), 32'd1);
    wait_strobe(7, 0, "ovr_pre_pos");
    check_eq("ovr_still_req", 32'(upd_req), 32'd1);
    check_eq("ovr_cnt_pre", 32'(overrun_cnt), 32'd0);
    repeat (5) @(negedge clk_x5);
    check_eq("ovr_pos_vc", 32'(vc), 32'd1);
    check_eq("ovr_pos_hc", 32'(hc), 32'd0);
    check_eq("ovr_req_drop", 32'(upd_req), 32'd0);
    check_eq("ovr_busy", 32'(upd_busy), 32'd0);
    check_eq("ovr_cnt_1", 32'(overrun_cnt), 32'd1);

    // Ack landing on the timeout edge wins.
    wait_strobe(0, 5, "tie_req_pos");
    check_eq("tie_req_up", 32'(upd_req), 32'd1);
    wait_strobe(7, 0, "tie_pre_pos");
    repeat (4) @(negedge clk_x5);
    upd_ack = 1'b1;
    @(negedge clk_x5);
    upd_ack = 1'b0;
    check_eq("tie_stb", 32'(pix_stb), 32'd1);
    check_eq("tie_vc", 32'(vc), 32'd1);
    check_eq("tie_req", 32'(upd_req), 32'd0);
    check_eq("tie_done_busy", 32'(upd_busy), 32'd1);
    check_eq("tie_cnt", 32'(overrun_cnt), 32'd1);
    @(negedge clk_x5);
    check_eq("tie_idle_busy", 32'(upd_busy), 32'd0);

    // Saturation: 258 further missed frames.
    for (int i = 0; i < 258; i++) begin
      wait_strobe(0, 1, "sat_frame");
      if (i == 99) check_eq("sat_cnt_101", 32'(overrun_cnt), 32'd101);
    end
    check_eq("sat_cnt_255", 32'(overrun_cnt), 32'd255);

    // Reset while a request is pending.
    wait_strobe(0, 5, "mid_req_pos");
    repeat (2) @(negedge clk_x5);
    check_eq("mid_req_up", 32'(upd_req), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(upd_req), 32'd0);
    check_eq("mid_rst_busy", 32'(upd_busy), 32'd0);
    check_eq("mid_rst_hc", 32'(hc), 32'd0);
    check_eq("mid_rst_vc", 32'(vc), 32'd0);
    check_eq("mid_rst_cnt", 32'(overrun_cnt), 32'd0);
    @(negedge clk_x5);
    resetn = 1'b1;
    req_highs = 0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk_x5);
      if (upd_req) req_highs++;
      if (pix_stb && hc == 10'd7 && vc == 10'd4) found = 1'b1;
    end
    check_eq("post_rst_reach", 32'(found), 32'd1);
    check_eq("post_rst_no_req", 32'(req_highs), 32'd0);
    repeat (5) @(negedge clk_x5);
    check_eq("post_rst_req_vc", 32'(vc), 32'd5);
    check_eq("post_rst_req_up", 32'(upd_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_frame_sequencer.md
# video_frame_sequencer

Owns the 25 MHz pixel cadence and raster position for the HDMI pong design, running entirely in the 125 MHz `clk_x5` domain. It produces the 1-in-5 pixel strobe that paces TMDS symbol latching, the raster counters and sync/active decodes consumed by the symbol encoder, and active-area coordinates for the sprite logic. Once per frame it schedules the game-state update through a req/ack handshake, and it detects and counts updates that miss their vertical-blanking window.

## Interface
Parameters:
- `DIV`, 5: `clk_x5` cycles per pixel.
- `HPIXELS`, 800: pixels per line; `hc` runs 0..HPIXELS-1.
- `VLINES`, 525: lines per frame; `vc` runs 0..VLINES-1.
- `HPULSE`, 96: hsync width in pixels.
- `VPULSE`, 2: vsync width in lines.
- `HBP`, 144: first active pixel.
- `HFP`, 784: first pixel after the active area.
- `VBP`, 35: first active line.
- `VFP`, 515: first line after the active area.

Ports:
- `clk_x5` in 1: 125 MHz clock.
- `resetn` in 1: asynchronous, active-low reset.
- `pix_stb` out 1: one-cycle pulse every DIV cycles.
- `hc` out 10: horizontal counter.
- `vc` out 10: vertical counter.
- `hac` out 10: `hc - HBP`, modulo 1024.
- `vac` out 10: `vc - VBP`, modulo 1024.
- `active` out 1: `HBP<=hc<HFP && VBP<=vc<VFP`.
- `hsync` out 1: `hc<HPULSE`.
- `vsync` out 1: `vc<VPULSE`.
- `upd_req` out 1: game update requested.
- `upd_ack` in 1: game logic completion.
- `upd_busy` out 1: FSM not IDLE.
- `overrun_cnt` out 8: saturating count of missed updates.

## Operation
- **Divider `div`:** counts 0..DIV-1 and wraps. `pix_stb` is registered and is high in the cycle where `div==DIV-1`.
- **Raster counters:** advance on the same clock edge that asserts `pix_stb`, so `pix_stb` and the new `hc` appear together.
  - `hc==HPIXELS-1`: `hc`→0 and `vc` increments.
  - `vc==VLINES-1` while `hc` wraps: `vc`→0.
  - `hc` and `vc` never exceed their maximums.
- **Decodes:** `hac`, `vac`, `active`, `hsync` and `vsync` are combinational from the registered `hc`/`vc`. They are valid in the same cycle as `hc`/`vc`.
- **Update FSM** (states IDLE, REQ, DONE):
  - IDLE→REQ: on the `pix_stb` cycle in which the counters become `vc==VFP, hc==0`.
  - REQ: `upd_req` is high. When `upd_ack` is sampled high, go to DONE.
  - REQ timeout: if no ack arrives and the counters become `vc==VBP, hc==0` on a `pix_stb`, drop the request, increment `overrun_cnt` (saturating at 255), and go to IDLE.
  - If ack and timeout occur in the same cycle, the ack wins: go to DONE and do not count an overrun.
  - DONE→IDLE: unconditionally after one cycle. This guarantees `upd_req` is low for at least one cycle between requests.
  - `upd_ack` is ignored in IDLE and DONE.
- **Reset:** `resetn` low at any time, including mid-REQ, forces every register to its reset value on the next evaluation. No request is carried over.
- **Reset values:**
  - `div=0`, `pix_stb=0`, `hc=0`, `vc=0`.
  - FSM in IDLE; `upd_req=0`, `upd_busy=0`, `overrun_cnt=0`.
  - Resulting decodes: `hac=1024-144=880`, `vac=989`, `active=0`, `hsync=1`, `vsync=1`.

## Timing
- First `pix_stb` occurs DIV cycles after reset release (cycle index DIV-1, counting the first clock after release as 0).
- Line period: HPIXELS·DIV = 4000 cycles. Frame period: 4000·525 = 2,100,000 cycles.
- `upd_req` rises on the `pix_stb` cycle that loads `vc=VFP, hc=0`.
- `upd_req` falls in the cycle after `upd_ack` is sampled high; ack-to-release latency is 1 cycle.
- `upd_busy` is high in REQ and DONE.
- Update window: from `vc=VFP` to `vc=VBP` of the next frame = (VLINES-VFP+VBP)·HPIXELS·DIV = 45·4000 = 180,000 cycles.
- On timeout, `overrun_cnt` updates in the same cycle that `upd_req` drops.

## Test plan
- **Reset values:** hold `resetn` low, then release. Outputs match the reset list. `pix_stb` pulses at cycles 4, 9, 14…; after the first pulse `hc=1`.
- **Line wrap:** run to `hc=799, vc=0`. The next `pix_stb` gives `hc=0, vc=1`. `hsync` is high exactly for `hc` 0–95. `active` stays 0 while `vc<35`.
- **Frame wrap:** at `vc=524, hc=799`, the next strobe gives `vc=0, hc=0` and `vsync=1`. At `vc=35, hc=144`: `active=1`, `hac=0`, `vac=0`.
- **Handshake:** `upd_req` rises when the counters reach `vc=515, hc=0`. Drive `upd_ack` 3 cycles later; `upd_req` is low the next cycle, DONE lasts one cycle, and `overrun_cnt` stays 0.
- **Overrun:** never ack. `upd_req` drops when the counters reach `vc=35, hc=0`, and `overrun_cnt` goes to 1. After 260 frames, `overrun_cnt=255`. Ack coinciding with the timeout leaves the count unchanged.
- **Reset mid-REQ:** assert `resetn` low while `upd_req=1`. `upd_req`, `hc` and `vc` clear immediately. After release, no request appears until `vc=515`.
